mdu_sequencer: RTL and testbench
================================

# mdu_sequencer

Multi-cycle sequencer for the multiply/divide resource (RV32M) inside the execution stage. It accepts an M-extension operation when the EX decoder selects the MDU. It then runs a fixed-latency multiply pipeline or a 32-iteration restoring divider. While the operation is in flight it holds `mul_stall_o`/`div_stall_o` high, which freezes the ID/EX and EX/MEM pipeline registers. When the result is ready it drops the stall for exactly the capture cycle, so the EX/MEM register samples `result_o`.

## Interface
- `MUL_LAT`, default 3: cycles spent in MUL_BUSY; legal range ≥1.
- `clk_i`, input, 1: clock; all state changes on the rising edge.
- `rst_i`, input, 1: reset, synchronous and active-high.
- `start_i`, input, 1: EX holds a valid MDU instruction (chip_select = MDU).
- `mdu_op_i`, input, 3: funct3 encoding.
  - 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU.
  - 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `op1_i`, input, 32: forwarded rs1 value.
- `op2_i`, input, 32: forwarded rs2 value.
- `freeze_i`, input, 1: memory busywait; the EX/MEM register will not capture this cycle.
- `flush_i`, input, 1: kills the in-flight instruction (branch redirect).
- `result_o`, output, 32: registered result; valid while `done_o`=1.
- `done_o`, output, 1: high in DONE state.
- `mul_stall_o`, output, 1: combinational stall for ops 000–011.
- `div_stall_o`, output, 1: combinational stall for ops 100–111.

## Operation
- States: IDLE, MUL_BUSY, DIV_BUSY, DIV_FIX, DONE. A 6-bit iteration counter is used by MUL_BUSY and DIV_BUSY.
- Priority: `rst_i` > `flush_i` > normal sequencing.
- IDLE with `start_i`=1:
  - Latch op, op1 and op2; later changes on these inputs are ignored.
  - Assert the matching stall combinationally in this same cycle.
- IDLE, multiply op:
  - Go to MUL_BUSY; the 64-bit product is computed over MUL_LAT cycles.
  - Operand signs: MUL/MULH are signed×signed, MULHSU is signed rs1 × unsigned rs2, MULHU is unsigned×unsigned.
  - MUL returns product[31:0]; the other three return product[63:32].
- IDLE, divide op:
  - Divide by zero: go straight to DONE with quotient = 0xFFFFFFFF and remainder = op1.
  - Signed overflow (DIV/REM with op1 = 0x80000000, op2 = 0xFFFFFFFF): go straight to DONE with quotient = 0x80000000 and remainder = 0.
  - Otherwise go to DIV_BUSY. Signed ops latch absolute values plus the sign bits.
- DIV_BUSY:
  - One restoring shift-subtract step per cycle, 32 steps, then go to DIV_FIX.
- DIV_FIX:
  - Quotient is negated if the operand signs differ (signed ops only).
  - Remainder takes the dividend's sign.
  - Load `result_o` and go to DONE.
- DONE:
  - Stalls low, `done_o`=1, `result_o` stable.
  - `freeze_i`=1: stay in DONE and keep holding the result.
  - `freeze_i`=0: go to IDLE next cycle. `start_i` still high in the DONE cycle (same instruction) must not restart.
- `freeze_i` has no effect in the busy states; computation continues.
- `flush_i`:
  - Both stalls are forced low in the same cycle.
  - State goes to IDLE next cycle and `result_o` is unchanged.
  - A `start_i` arriving in the flush cycle is ignored.
- If `start_i` drops mid-operation without a flush, the operation still completes.

## Timing
- Reset values:
  - state = IDLE, counter = 0.
  - `result_o` = 0, `done_o` = 0, `mul_stall_o` = 0, `div_stall_o` = 0.
- Multiply, with start seen at cycle T0:
  - Stall high T0..T(MUL_LAT); DONE at T(MUL_LAT+1).
  - That is MUL_LAT+1 stall cycles; the default gives 4.
- Divide, normal path:
  - Stall high T0..T33; DIV_BUSY is T1..T32 and DIV_FIX is T33.
  - DONE at T34, i.e. 34 stall cycles.
- Divide, special case: stall high at T0 only; DONE at T1.
- Back-to-back MDU ops: the earliest restart is the cycle after DONE, when the new instruction is in IDLE.
- `mul_stall_o` and `div_stall_o` are never high together.

## Test plan
- MUL 7 × 0xFFFFFFFD with MUL_LAT=3 → `mul_stall_o` high exactly 4 cycles, then `result_o`=0xFFFFFFEB with `done_o`=1 for one cycle.
- MULH 0x80000000 × 0x80000000 → 0x40000000.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
- MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD with `div_stall_o` high exactly 34 cycles; REM with the same operands → 0xFFFFFFFF.
- DIVU 100 / 0 → 0xFFFFFFFF; REMU 100 / 0 → 100; each with 1 stall cycle.
- DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM with the same operands → 0; each with 1 stall cycle.
- `freeze_i` high for 3 cycles during DONE of DIVU 50/7 → `result_o`=7 held for the 3 cycles, stalls low, no restart.
- `flush_i` at the 10th DIV_BUSY cycle → `div_stall_o` low in the same cycle, IDLE next cycle; a following MUL 3×5 returns 15.
- `rst_i` pulsed during MUL_BUSY → all outputs read their reset values on the next cycle.

Source files
------------

// File: rtl/mdu_sequencer.sv
// RV32M multiply/divide sequencer: fixed-latency multiply, 32-step restoring divide.
// Holds the EX stall while busy and presents a registered result in DONE.
module mdu_sequencer #(
  parameter int MUL_LAT = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [2:0]  mdu_op_i,
  input  logic [31:0] op1_i,
  input  logic [31:0] op2_i,
  input  logic        freeze_i,
  input  logic        flush_i,
  output logic [31:0] result_o,
  output logic        done_o,
  output logic        mul_stall_o,
  output logic        div_stall_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL_BUSY,
    S_DIV_BUSY,
    S_DIV_FIX,
    S_DONE
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [5:0]  r_cnt;
  logic [1:0]  r_op;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [31:0] r_rem;
  logic [31:0] r_result;
  logic        r_neg_q;
  logic        r_neg_r;
  logic        w_mul_stall;
  logic        w_div_stall;

  logic        w_is_div;
  logic        w_div_zero;
  logic        w_div_ovf;
  logic        w_op1_neg;
  logic        w_op2_neg;
  logic [31:0] w_abs1;
  logic [31:0] w_abs2;
  logic        w_mul_sa;
  logic        w_mul_sb;
  logic [63:0] w_ma;
  logic [63:0] w_mb;
  logic [63:0] w_prod;
  logic [32:0] w_shift;
  logic [32:0] w_sub;
  logic        w_mul_last;
  logic        w_div_last;

  assign w_is_div   = mdu_op_i[2];
  assign w_div_zero = (op2_i == 32'd0);
  assign w_div_ovf  = !mdu_op_i[0] && (op1_i == 32'h8000_0000) && (op2_i == 32'hFFFF_FFFF);
  // Signed divide ops (DIV, REM) have funct3[0] clear.
  assign w_op1_neg  = !mdu_op_i[0] && op1_i[31];
  assign w_op2_neg  = !mdu_op_i[0] && op2_i[31];
  assign w_abs1     = w_op1_neg ? -op1_i : op1_i;
  assign w_abs2     = w_op2_neg ? -op2_i : op2_i;

  // Sign-extend to 64 bits; the low 64 bits of the product are then exact for every signedness mix.
  assign w_mul_sa   = (r_op != 2'b11);
  assign w_mul_sb   = !r_op[1];
  assign w_ma       = {{32{w_mul_sa & r_a[31]}}, r_a};
  assign w_mb       = {{32{w_mul_sb & r_b[31]}}, r_b};
  assign w_prod     = w_ma * w_mb;

  // r_a shifts out dividend bits at the top and collects quotient bits at the bottom.
  assign w_shift    = {r_rem, r_a[31]};
  assign w_sub      = w_shift - {1'b0, r_b};
  assign w_mul_last = (r_cnt == 6'(MUL_LAT - 1));
  assign w_div_last = (r_cnt == 6'd31);

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_mul_stall = 1'b0;
    w_div_stall = 1'b0;
    if (flush_i) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            if (w_is_div) begin
              w_div_stall = 1'b1;
              w_next      = (w_div_zero || w_div_ovf) ? S_DONE : S_DIV_BUSY;
            end else begin
              w_mul_stall = 1'b1;
              w_next      = S_MUL_BUSY;
            end
          end
        end
        S_MUL_BUSY: begin
          w_mul_stall = 1'b1;
          if (w_mul_last) w_next = S_DONE;
        end
        S_DIV_BUSY: begin
          w_div_stall = 1'b1;
          if (w_div_last) w_next = S_DIV_FIX;
        end
        S_DIV_FIX: begin
          w_div_stall = 1'b1;
          w_next      = S_DONE;
        end
        S_DONE: begin
          if (!freeze_i) w_next = S_IDLE;
        end
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt    <= 6'd0;
      r_op     <= 2'd0;
      r_a      <= 32'd0;
      r_b      <= 32'd0;
      r_rem    <= 32'd0;
      r_result <= 32'd0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
    end else if (!flush_i) begin
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_op  <= mdu_op_i[1:0];
            r_cnt <= 6'd0;
            r_rem <= 32'd0;
            if (w_is_div) begin
              r_a     <= w_abs1;
              r_b     <= w_abs2;
              r_neg_q <= w_op1_neg ^ w_op2_neg;
              r_neg_r <= w_op1_neg;
              if (w_div_zero)     r_result <= mdu_op_i[1] ? op1_i : 32'hFFFF_FFFF;
              else if (w_div_ovf) r_result <= mdu_op_i[1] ? 32'd0 : 32'h8000_0000;
            end else begin
              r_a <= op1_i;
              r_b <= op2_i;
            end
          end
        end
        S_MUL_BUSY: begin
          r_cnt <= r_cnt + 6'd1;
          if (w_mul_last) r_result <= (r_op == 2'b00) ? w_prod[31:0] : w_prod[63:32];
        end
        S_DIV_BUSY: begin
          r_cnt <= r_cnt + 6'd1;
          r_a   <= {r_a[30:0], ~w_sub[32]};
          r_rem <= w_sub[32] ? w_shift[31:0] : w_sub[31:0];
        end
        S_DIV_FIX: begin
          r_cnt    <= 6'd0;
          r_result <= r_op[1] ? (r_neg_r ? -r_rem : r_rem) : (r_neg_q ? -r_a : r_a);
        end
        default: ;
      endcase
    end
  end

  assign result_o    = r_result;
  assign done_o      = (r_state == S_DONE);
  assign mul_stall_o = w_mul_stall;
  assign div_stall_o = w_div_stall;

endmodule

// File: tb/tb_mdu_sequencer.sv
// Directed bench for mdu_sequencer: results, stall lengths, special divides, freeze, flush and reset.
module tb_mdu_sequencer;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  mdu_op;
  logic [31:0] op1;
  logic [31:0] op2;
  logic        freeze;
  logic        flush;
  logic [31:0] result;
  logic        done;
  logic        mul_stall;
  logic        div_stall;

  int checks = 0;
  int passes = 0;

  mdu_sequencer #(.MUL_LAT(3)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (start),
    .mdu_op_i    (mdu_op),
    .op1_i       (op1),
    .op2_i       (op2),
    .freeze_i    (freeze),
    .flush_i     (flush),
    .result_o    (result),
    .done_o      (done),
    .mul_stall_o (mul_stall),
    .div_stall_o (div_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Issue one op and hold start until DONE; operands are scrambled after T0 to prove they were latched.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res, input int exp_stalls);
    int          stalls;
    int          bad;
    bit          got;
    logic [31:0] res;
    stalls = 0;
    bad    = 0;
    got    = 1'b0;
    res    = 32'hDEAD_BEEF;
    start  = 1'b1;
    mdu_op = op;
    op1    = a;
    op2    = b;
    for (int i = 0; i < 100 && !got; i++) begin
      #1;
      if (mul_stall && div_stall) bad++;
      else if (op[2] ? mul_stall : div_stall) bad++;
      if (mul_stall || div_stall) stalls++;
      if (done) begin
        got = 1'b1;
        res = result;
      end else begin
        @(posedge clk);
        #1;
        op1 = $urandom;
        op2 = $urandom;
      end
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    #1;
    check({tag, "_done_seen"}, 64'(got), 64'd1);
    check({tag, "_result"}, 64'(res), 64'(exp_res));
    check({tag, "_stall_cycles"}, 64'(stalls), 64'(exp_stalls));
    check({tag, "_stall_select"}, 64'(bad), 64'd0);
    check({tag, "_done_one_cycle"}, 64'(done), 64'd0);
  endtask

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    mdu_op = 3'b000;
    op1    = 32'd0;
    op2    = 32'd0;
    freeze = 1'b0;
    flush  = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("reset_outputs", {29'd0, result, done, mul_stall, div_stall}, 64'd0);

    run_op("mul",    3'b000, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 4);
    run_op("mulh",   3'b001, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 4);
    run_op("mulhu",  3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 4);
    run_op("mulhsu", 3'b010, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 4);
    run_op("div",    3'b100, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 34);
    run_op("rem",    3'b110, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 34);
    run_op("divu0",  3'b101, 32'd100,        32'd0,         32'hFFFF_FFFF, 1);
    run_op("remu0",  3'b111, 32'd100,        32'd0,         32'd100,       1);
    run_op("divovf", 3'b100, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_op("removf", 3'b110, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1);
    run_op("divu",   3'b101, 32'd1000,       32'd7,         32'd142,       34);

    // Freeze over DONE of DIVU 50/7, start held high throughout.
    freeze = 1'b1;
    start  = 1'b1;
    mdu_op = 3'b101;
    op1    = 32'd50;
    op2    = 32'd7;
    #1;
    for (int i = 0; i < 60 && done !== 1'b1; i++) begin
      @(posedge clk);
      #2;
    end
    check("freeze_reach_done", 64'(done), 64'd1);
    for (int k = 0; k < 4; k++) begin
      if (k == 3) freeze = 1'b0;
      #1;
      check("freeze_result", 64'(result), 64'd7);
      check("freeze_done", 64'(done), 64'd1);
      check("freeze_stalls", {62'd0, mul_stall, div_stall}, 64'd0);
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    #1;
    check("freeze_release_idle", {62'd0, done, mul_stall | div_stall}, 64'd0);

    // Flush on the 10th DIV_BUSY cycle.
    start  = 1'b1;
    mdu_op = 3'b100;
    op1    = 32'd1000;
    op2    = 32'd3;
    #1;
    repeat (10) @(posedge clk);
    #1;
    flush = 1'b1;
    #1;
    check("flush_stall_low", {62'd0, mul_stall, div_stall}, 64'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    start = 1'b0;
    #1;
    check("flush_idle", {62'd0, done, mul_stall | div_stall}, 64'd0);
    check("flush_result_kept", 64'(result), 64'd7);

    // Start coinciding with flush in IDLE is dropped.
    start  = 1'b1;
    mdu_op = 3'b000;
    op1    = 32'd3;
    op2    = 32'd5;
    flush  = 1'b1;
    #1;
    check("flush_start_stall", 64'(mul_stall), 64'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    start = 1'b0;
    #1;
    check("flush_start_ignored", {62'd0, mul_stall, div_stall}, 64'd0);

    run_op("mul_after_flush", 3'b000, 32'd3, 32'd5, 32'd15, 4);

    // Reset pulsed while in MUL_BUSY.
    start  = 1'b1;
    mdu_op = 3'b000;
    op1    = 32'd2;
    op2    = 32'd2;
    @(posedge clk);
    #1;
    start = 1'b0;
    #1;
    check("rst_in_mul_busy", 64'(mul_stall), 64'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("rst_outputs", {29'd0, result, done, mul_stall, div_stall}, 64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
